// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Opcode/funct constants and jb_flag encodings shared by the MIPS control path.
// Also holds the operand-match helper used by hazard detection.
package pipeline_hazard_ctrl_pkg;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        JB_NONE   = 2'b00,
        JB_BRANCH = 2'b01,
        JB_JUMP   = 2'b10,
        JB_BOTH   = 2'b11
    } jb_flag_e;

    localparam int MD_CNT_W = 6;

    // r is read by the ID instruction; $zero never creates a dependency
    function automatic logic src_hit(input logic [4:0] r,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       invalid_rt);
        return (r != 5'd0) && ((r == rs) || (!invalid_rt && (r == rt)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_md_scheduler.sv
// Occupancy tracker for the shared MULT/DIV unit: issue pulse, latency
// select and the down-counter that drives md_busy.
module md_scheduler
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       is_md,
    input  logic [5:0] id_funct,
    input  logic       stall,
    output logic       md_start,
    output logic       md_busy
);

    logic [MD_CNT_W-1:0] md_cnt_r;
    logic [MD_CNT_W-1:0] lat_s;

    // Latency select, issue pulse and busy flag (forced idle during reset)
    always_comb begin
        case (id_funct)
            FN_DIV, FN_DIVU:   lat_s = MD_CNT_W'(DIV_LAT);
            FN_MULT, FN_MULTU: lat_s = MD_CNT_W'(MUL_LAT);
            default:           lat_s = MD_CNT_W'(MUL_LAT);
        endcase
        md_start = !reset && !stall && is_md;
        md_busy  = !reset && (md_cnt_r != {MD_CNT_W{1'b0}});
    end

    // Occupancy counter; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt_r <= {MD_CNT_W{1'b0}};
        end else if (md_start) begin
            md_cnt_r <= lat_s;
        end else if (md_cnt_r != {MD_CNT_W{1'b0}}) begin
            md_cnt_r <= md_cnt_r - MD_CNT_W'(1);
        end else begin
            md_cnt_r <= md_cnt_r;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ID-stage stall/flush sequencer: load-use, branch-operand and MULT/DIV
// hazards, taken-branch/jump flush, and stall/flush performance counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  id_op,
    input  logic [5:0]  id_funct,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_invalid_rt,
    input  logic [1:0]  jb_flag,
    input  logic        ex_reg_write,
    input  logic        ex_mem_to_reg,
    input  logic [4:0]  ex_write_reg,
    input  logic        mem_mem_to_reg,
    input  logic [4:0]  mem_write_reg,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        ctl_mux,
    output logic        md_start,
    output logic        md_busy,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    logic is_md_s, is_mdr_s, is_br_s, is_jr_s;
    logic ex_hit_s, mem_hit_s;
    logic load_use_s, br_haz_s, md_haz_s, stall_s;

    // Instruction decode and hazard detection
    always_comb begin
        is_md_s    = (id_op == OP_R) && (id_funct == FN_MULT || id_funct == FN_MULTU ||
                                         id_funct == FN_DIV  || id_funct == FN_DIVU);
        is_mdr_s   = (id_op == OP_R) && (id_funct == FN_MFHI || id_funct == FN_MFLO);
        is_br_s    = (id_op == OP_BEQ) || (id_op == OP_BNE);
        is_jr_s    = (id_op == OP_R) && (id_funct == FN_JR);
        ex_hit_s   = src_hit(ex_write_reg, id_rs, id_rt, id_invalid_rt);
        mem_hit_s  = src_hit(mem_write_reg, id_rs, id_rt, id_invalid_rt);
        load_use_s = ex_mem_to_reg && ex_hit_s;
        // ID resolves branches, so ALU results in EX and loads in MEM are too late
        br_haz_s   = (is_br_s || is_jr_s) &&
                     ((ex_reg_write && ex_hit_s) || (mem_mem_to_reg && mem_hit_s));
        md_haz_s   = md_busy && (is_md_s || is_mdr_s);
        stall_s    = load_use_s || br_haz_s || md_haz_s;
    end

    md_scheduler #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md_scheduler (
        .clk      (clk),
        .reset    (reset),
        .is_md    (is_md_s),
        .id_funct (id_funct),
        .stall    (stall_s),
        .md_start (md_start),
        .md_busy  (md_busy)
    );

    // Pipeline enables: reset holds a flushed bubble, stall beats flush
    always_comb begin
        if (reset) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ctl_mux    = 1'b1;
            ifid_flush = 1'b1;
        end else if (stall_s) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ctl_mux    = 1'b1;
            ifid_flush = 1'b0;
        end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ctl_mux    = 1'b0;
            ifid_flush = (jb_flag != JB_NONE);
        end
    end

    // Performance counters, wrapping modulo 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            stall_cnt <= stall_s    ? stall_cnt + 32'd1 : stall_cnt;
            flush_cnt <= ifid_flush ? flush_cnt + 32'd1 : flush_cnt;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: stimulus queues hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic        pc;
        logic        ifw;
        logic        fl;
        logic        cm;
        logic        ms;
        logic        mb;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  id_op, id_funct;
    logic [4:0]  id_rs, id_rt;
    logic        id_invalid_rt;
    logic [1:0]  jb_flag;
    logic        ex_reg_write, ex_mem_to_reg;
    logic [4:0]  ex_write_reg;
    logic        mem_mem_to_reg;
    logic [4:0]  mem_write_reg;
    logic        pc_write, ifid_write, ifid_flush, ctl_mux, md_start, md_busy;
    logic [31:0] stall_cnt, flush_cnt;

    exp_t sb[$];
    exp_t tags[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;
    int   step_q[$];

    pipeline_hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(32)) dut (
        .clk(clk), .reset(reset),
        .id_op(id_op), .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt),
        .id_invalid_rt(id_invalid_rt), .jb_flag(jb_flag),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_write_reg(ex_write_reg), .mem_mem_to_reg(mem_mem_to_reg),
        .mem_write_reg(mem_write_reg),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .ctl_mux(ctl_mux), .md_start(md_start), .md_busy(md_busy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic set_id(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                          input logic [4:0] rt, input logic inv, input logic [1:0] jb);
        id_op = op; id_funct = fn; id_rs = rs; id_rt = rt; id_invalid_rt = inv; jb_flag = jb;
    endtask

    task automatic set_back(input logic exrw, input logic exm2r, input logic [4:0] exwr,
                            input logic mm2r, input logic [4:0] mwr);
        ex_reg_write = exrw; ex_mem_to_reg = exm2r; ex_write_reg = exwr;
        mem_mem_to_reg = mm2r; mem_write_reg = mwr;
    endtask

    task automatic nop();
        set_id(6'd0, 6'd0, 5'd0, 5'd0, 1'b0, 2'b00);
        set_back(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    // Queue the expectation for the current cycle, then move to the next cycle
    task automatic chk(input logic pc, input logic ifw, input logic fl, input logic cm,
                       input logic ms, input logic mb, input int sc, input int fc);
        exp_t e;
        e = '{pc: pc, ifw: ifw, fl: fl, cm: cm, ms: ms, mb: mb, sc: 32'(sc), fc: 32'(fc)};
        step_no++;
        sb.push_back(e);
        step_q.push_back(step_no);
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e, a;
            int   s;
            e = sb.pop_front();
            s = step_q.pop_front();
            a = '{pc: pc_write, ifw: ifid_write, fl: ifid_flush, cm: ctl_mux,
                  ms: md_start, mb: md_busy, sc: stall_cnt, fc: flush_cnt};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL step%0d got pc/ifw/fl/cm/ms/mb=%b%b%b%b%b%b sc=%0d fc=%0d want %b%b%b%b%b%b sc=%0d fc=%0d",
                         s, a.pc, a.ifw, a.fl, a.cm, a.ms, a.mb, a.sc, a.fc,
                         e.pc, e.ifw, e.fl, e.cm, e.ms, e.mb, e.sc, e.fc);
            end
        end
    end

    initial begin
        reset = 1'b1;
        nop();
        @(posedge clk); #1;
        chk(0,0,1,1,0,0, 0,0);                                  // reset state
        reset = 1'b0;
        chk(1,1,0,0,0,0, 0,0);                                  // idle
        // LW $t0 in EX, ADD $t1,$t0,$t2 in ID
        set_id(6'b000000, 6'b100000, 5'd8, 5'd10, 1'b0, 2'b00);
        set_back(1'b1, 1'b1, 5'd8, 1'b0, 5'd0);
        chk(0,0,0,1,0,0, 0,0);
        set_back(1'b0, 1'b0, 5'd0, 1'b1, 5'd8);
        chk(1,1,0,0,0,0, 1,0);
        // LW $t0 in EX, BEQ $t0,$zero in ID: two stall cycles, then flush
        set_id(6'b000100, 6'b000000, 5'd8, 5'd0, 1'b0, 2'b01);
        set_back(1'b1, 1'b1, 5'd8, 1'b0, 5'd0);
        chk(0,0,0,1,0,0, 1,0);
        set_back(1'b0, 1'b0, 5'd0, 1'b1, 5'd8);
        chk(0,0,0,1,0,0, 2,0);
        set_back(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        chk(1,1,1,0,0,0, 3,0);
        nop();
        chk(1,1,0,0,0,0, 3,1);
        // Load to $t0 in EX, ID rt=$t0 but rt is not a source
        set_id(6'b001000, 6'b000000, 5'd9, 5'd8, 1'b1, 2'b00);
        set_back(1'b1, 1'b1, 5'd8, 1'b0, 5'd0);
        chk(1,1,0,0,0,0, 3,1);
        // Load to $zero never stalls
        set_id(6'b000000, 6'b100000, 5'd0, 5'd0, 1'b0, 2'b00);
        set_back(1'b1, 1'b1, 5'd0, 1'b0, 5'd0);
        chk(1,1,0,0,0,0, 3,1);
        // Jump, then jb_flag=11
        nop();
        set_id(6'b000010, 6'b000000, 5'd0, 5'd0, 1'b1, 2'b10);
        chk(1,1,1,0,0,0, 3,1);
        set_id(6'b000000, 6'b000000, 5'd0, 5'd0, 1'b0, 2'b11);
        chk(1,1,1,0,0,0, 3,2);
        nop();
        chk(1,1,0,0,0,0, 3,3);
        // MULT then MFLO: 4 stall cycles
        set_id(6'b000000, 6'b011000, 5'd9, 5'd10, 1'b0, 2'b00);
        chk(1,1,0,0,1,0, 3,3);
        set_id(6'b000000, 6'b010010, 5'd0, 5'd0, 1'b1, 2'b00);
        for (int i = 0; i < 4; i++) chk(0,0,0,1,0,1, 3+i,3);
        chk(1,1,0,0,0,0, 7,3);
        // Back-to-back MULT: second issues once busy drops
        set_id(6'b000000, 6'b011001, 5'd9, 5'd10, 1'b0, 2'b00);
        chk(1,1,0,0,1,0, 7,3);
        for (int i = 0; i < 4; i++) chk(0,0,0,1,0,1, 7+i,3);
        chk(1,1,0,0,1,0, 11,3);
        // MD hazard and load-use together: one stall count
        set_id(6'b000000, 6'b010000, 5'd8, 5'd0, 1'b1, 2'b00);
        set_back(1'b1, 1'b1, 5'd8, 1'b0, 5'd0);
        chk(0,0,0,1,0,1, 11,3);
        nop();
        for (int i = 0; i < 3; i++) chk(1,1,0,0,0,1, 12,3);
        chk(1,1,0,0,0,0, 12,3);
        // DIV, run down to md_cnt=20, then reset
        set_id(6'b000000, 6'b011010, 5'd9, 5'd10, 1'b0, 2'b00);
        chk(1,1,0,0,1,0, 12,3);
        nop();
        for (int i = 0; i < 12; i++) chk(1,1,0,0,0,1, 12,3);
        reset = 1'b1;
        chk(0,0,1,1,0,0, 12,3);
        reset = 1'b0;
        set_id(6'b000000, 6'b010010, 5'd0, 5'd0, 1'b1, 2'b00);
        chk(1,1,0,0,0,0, 0,0);
        // JR $t0 with ALU result for $t0 in EX: stall, then flush
        set_id(6'b000000, 6'b001000, 5'd8, 5'd0, 1'b1, 2'b10);
        set_back(1'b1, 1'b0, 5'd8, 1'b0, 5'd0);
        chk(0,0,0,1,0,0, 0,0);
        set_back(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        chk(1,1,1,0,0,0, 1,0);
        nop();
        chk(1,1,0,0,0,0, 1,1);
        @(negedge clk); #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Stall, flush and issue sequencer for the 5-stage MIPS pipeline. Sits beside the ID stage and drives the PC and IF/ID write enables, the IF/ID flush, and the `ctl_mux` bubble select into the main control unit. It detects load-use and branch-operand hazards and flushes on taken branches or jumps. It also schedules a shared multi-cycle MULT/DIV unit through a latency counter and provides stall and flush performance counters.

## Interface
- `MUL_LAT`, default 4: cycles MULT/MULTU occupies the MD unit (≥1).
- `DIV_LAT`, default 32: cycles DIV/DIVU occupies the MD unit (≥1).
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `id_op`, `id_funct` in 6 each: opcode and funct of the instruction in ID.
- `id_rs`, `id_rt` in 5 each: source register fields in ID.
- `id_invalid_rt` in 1: rt is not a source operand (I-type dest, J, JR).
- `jb_flag` in 2: 01 taken branch, 10 jump/JAL/JR, 00 none (ID-resolved).
- `ex_reg_write`, `ex_mem_to_reg` in 1 each: ID/EX control of the instruction in EX.
- `ex_write_reg` in 5: destination of the instruction in EX.
- `mem_mem_to_reg` in 1: EX/MEM memtoreg.
- `mem_write_reg` in 5: destination of the instruction in MEM.
- `pc_write` out 1: PC update enable.
- `ifid_write` out 1: IF/ID register enable.
- `ifid_flush` out 1: zero the IF/ID instruction next edge.
- `ctl_mux` out 1: force the control unit outputs to zero (bubble).
- `md_start` out 1: MULT/DIV issue pulse to the MD unit.
- `md_busy` out 1: MD unit occupied.
- `stall_cnt` out 32: cycles with `pc_write`=0 since reset.
- `flush_cnt` out 32: flushes since reset.

## Operation
- Decode in ID: `is_md` for funct 011000–011011 with op=0; `is_mdr` for MFHI 010000 / MFLO 010010; `is_br` for op 000100/000101; `is_jr` for op=0, funct 001000.
- `src_hit(r)` = r≠0 and (r==`id_rs` or (!`id_invalid_rt` and r==`id_rt`)).
- Load-use hazard: `ex_mem_to_reg` and `src_hit(ex_write_reg)`.
- Branch-operand hazard, for `is_br` or `is_jr`:
  - `ex_reg_write` and `src_hit(ex_write_reg)`, or
  - `mem_mem_to_reg` and `src_hit(mem_write_reg)`.
  - A load feeding a branch therefore stalls 2 cycles.
- MD hazard: `md_busy` and (`is_md` or `is_mdr`).
- `stall` = any of the three hazards.
  - While stalled: `pc_write`=0, `ifid_write`=0, `ctl_mux`=1, `md_start`=0, `ifid_flush`=0.
  - Stall has priority over flush; `jb_flag` is ignored while stalled.
- Flush: !`stall` and `jb_flag`≠00 → `ifid_flush`=1 for one cycle, with `pc_write`=`ifid_write`=1. `jb_flag`=11 is treated as a flush.
- MD scheduler: counter `md_cnt` (6 bits, sized to max latency).
  - On !`stall` and `is_md`: `md_start`=1 and `md_cnt` ← the op's latency.
  - Otherwise, when `md_cnt`≠0, decrement by one per cycle.
  - `md_busy` = (`md_cnt`≠0).
- Counters:
  - `stall_cnt` increments each cycle `stall`=1.
  - `flush_cnt` increments each cycle `ifid_flush`=1.
  - Both wrap modulo 2^32.
- Reset:
  - Counters and `md_cnt` clear to 0.
  - While `reset`=1: `pc_write`=0, `ifid_write`=0, `ctl_mux`=1, `ifid_flush`=1, `md_start`=0, `md_busy`=0.
  - An MD operation in flight at reset is abandoned.

## Timing
- Hazard, flush and `md_start` outputs are combinational from ID/EX/MEM inputs and `md_cnt`. No extra latency.
- MULT issued at edge t: `md_busy`=1 for cycles t+1..t+MUL_LAT, 0 at t+MUL_LAT+1.
  - An MFLO in ID during cycles t+1..t+MUL_LAT stalls.
  - It issues in cycle t+MUL_LAT+1.
- Back-to-back MULT stalls until `md_busy`=0, then issues that same cycle.
- Simultaneous MD hazard and load-use: a single stall. `stall_cnt` increments by 1 per cycle.
- The counter increments for a cycle are committed at that cycle's rising edge.

## Structure
- Shared package (e.g. `mips_pkg`): opcode/funct constants (R, BEQ, BNE, J, JAL, JR, MULT/MULTU/DIV/DIVU, MFHI/MFLO) and the `jb_flag` encodings. Reuse the constants the control unit uses.
- One sub-module: `md_scheduler`, holding `md_cnt`, the latency select, `md_start` and `md_busy`.
- Hazard detection and counters stay in the top module.

## Test plan
- LW $t0 in EX, ADD $t1,$t0,$t2 in ID → one cycle of `pc_write`=0, `ctl_mux`=1; `stall_cnt`=1.
- LW $t0 in EX, then BEQ $t0,$zero in ID → stalls 2 consecutive cycles; the flush happens only when `jb_flag`=01 with no stall.
- ADDI $t0 in EX, with `id_invalid_rt`=1 and `id_rt`=$t0 → no stall.
- Jump with `jb_flag`=10 → `ifid_flush`=1 for one cycle; `flush_cnt` 0→1.
- MULT issued, MFLO next cycle, MUL_LAT=4 → MFLO stalls 4 cycles, then proceeds; `md_start` pulses once.
- DIV in flight (`md_cnt`=20) and reset asserted → next cycle `md_busy`=0 and counters are 0. While `reset`=1, `ifid_flush`=1 and `ctl_mux`=1.
